lcd_msg_sequencer: RTL and testbench
====================================

LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

Interface
REQ-001 SHALL have parameter CHARS_PER_LINE, default 16, characters per display line (1..16).
REQ-002 SHALL have parameter NUM_LINES, default 2, display lines refreshed (1 or 2 only).
REQ-003 SHALL have port Clock  input  1  system clock, 50 MHz; the single clock, all logic on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host write strobe into the message buffer.
REQ-006 SHALL have port wr_addr  input  5  buffer address; 0..15 is line 1, 16..31 is line 2.
REQ-007 SHALL have port wr_data  input  8  ASCII character to store.
REQ-008 SHALL have port start  input  1  one-cycle pulse that requests a full display refresh.
REQ-009 SHALL have port busy  output  1  high while a refresh sequence is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a refresh completes.
REQ-011 SHALL have port req_valid  output  1  request to the downstream LCD controller is pending.
REQ-012 SHALL have port req_rs  output  1  request type: 0 = command, 1 = character data.
REQ-013 SHALL have port req_data  output  8  command or character byte.
REQ-014 SHALL have port req_ready  input  1  downstream LCD controller accepts the request this cycle.

Function
REQ-015 SHALL use a state machine with states IDLE, CLEAR, ADDR_L1, CHARS_L1, ADDR_L2, CHARS_L2 and DONE.
REQ-016 SHALL treat a request as accepted only in a cycle where req_valid and req_ready are both 1.
REQ-017 SHALL advance the state machine or character index only when a request is accepted.
REQ-018 SHALL hold req_rs and req_data stable while req_valid=1 and req_ready=0.
REQ-019 SHALL register all outputs.
REQ-020 SHALL, when start=1 is sampled in IDLE at cycle N, raise busy and req_valid at N+1.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL present the next request at k+1 after an accept at cycle k, with no idle cycle between requests.
REQ-023 SHALL issue in CLEAR the command 0x01.
REQ-024 SHALL issue in ADDR_L1 the command 0x80.
REQ-025 SHALL issue in ADDR_L2 the command 0xC0.
REQ-026 SHALL issue in CHARS_Lx the buffer entries for indices 0..CHARS_PER_LINE-1 of line x, with req_rs=1.
REQ-027 SHALL, when NUM_LINES=1, go directly from the last CHARS_L1 accept to DONE.
REQ-028 SHALL, in DONE, drive req_valid=0 and busy=0, pulse done for exactly one cycle, and then return to IDLE.
REQ-029 SHALL pulse done in the cycle after the last accept.
REQ-030 SHALL use a character index counter $clog2(CHARS_PER_LINE) bits wide that wraps to 0 on each line change.
REQ-031 SHALL accept host buffer writes in any state; a write takes effect in the next cycle.
REQ-032 SHALL load req_data from the buffer when a request is launched, so a same-cycle write to that address issues the old value.
REQ-033 SHALL send characters for later indices using data written mid-refresh.
REQ-034 SHALL ignore wr_addr values 16..31 when NUM_LINES=1.

Reset
REQ-035 SHALL, when Reset=1 is sampled, next cycle be in IDLE with busy=0, done=0, req_valid=0, req_rs=0, req_data=0x00 and index=0.
REQ-036 SHALL let Reset abort a refresh mid-sequence at once, including a request that has not yet been accepted.
REQ-037 SHALL give Reset priority over start, wr_en and req_ready.
REQ-038 SHALL, on Reset, set every buffer entry to 0x20 (space).

Configuration
REQ-039 SHALL, with macro LCD_SEQ_CLEAR_EN defined, begin each sequence with CLEAR (35 transactions when NUM_LINES=2).
REQ-040 SHALL, without LCD_SEQ_CLEAR_EN, exclude the CLEAR state; the sequence begins at ADDR_L1 (34 transactions when NUM_LINES=2).

Structure
REQ-041 SHALL place CMD_CLEAR=0x01, CMD_SET_DDRAM=0x80, LINE2_OFFSET=0x40 and the state enum typedef in shared package lcd_pkg, also used by the LCD controller.
REQ-042 SHALL implement the 32x8 message buffer in sub-module lcd_msg_buffer, with a synchronous write, a read port and the space-initialising reset.

Verification
REQ-043 SHALL cover: Reset, write "HELLO" at addresses 0..4, start, req_ready held 1 -> requests 0x01, 0x80, 'H','E','L','L','O', eleven 0x20, 0xC0, sixteen 0x20; done pulses the cycle after the last accept.
REQ-044 SHALL cover: req_ready low for 3 cycles on the 0x80 request -> req_valid, req_rs=0 and req_data=0x80 held 3 cycles; the sequence continues after accept.
REQ-045 SHALL cover: start pulsed again while busy -> ignored; exactly one done pulse and one sequence.
REQ-046 SHALL cover: Reset asserted during CHARS_L1 at index 5 -> next cycle req_valid=0, busy=0; buffer reads all 0x20 afterwards.
REQ-047 SHALL cover: write 'Z' to address 20 while index 2 of line 1 is pending -> 'Z' is sent at line 2 position 4.
REQ-048 SHALL cover: build without LCD_SEQ_CLEAR_EN and with NUM_LINES=1 -> 17 requests, the first is 0x80, and no 0xC0 is issued.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: HD44780-style command bytes, buffer layout
// constants and the refresh sequencer state encoding.
// Optional macro LCD_SEQ_CLEAR_EN adds the CLEAR state to the sequence.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
    localparam logic [7:0] LINE2_OFFSET   = 8'h40;

    localparam logic [7:0] CHAR_BLANK     = 8'h20;
    localparam logic [4:0] BUF_LINE2_BASE = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
`ifdef LCD_SEQ_CLEAR_EN
        S_CLEAR    = 3'd1,
`endif
        S_ADDR_L1  = 3'd2,
        S_CHARS_L1 = 3'd3,
        S_ADDR_L2  = 3'd4,
        S_CHARS_L2 = 3'd5,
        S_DONE     = 3'd6
    } lcd_seq_state_e;

endpackage

// File: rtl/lcd_msg_buffer.sv
// 32x8 message buffer: synchronous write, asynchronous read, reset to spaces.
// Ports: clk_i, rst_i (sync, active high), wr_en_i/wr_addr_i/wr_data_i
// write port, rd_addr_i/rd_data_o read port. Macro: none used here.
module lcd_msg_buffer
    import lcd_pkg::*;
#(
    parameter int NUM_LINES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [32];
    logic       wr_ok;

    // Line 2 addresses are dropped on a single-line display.
    assign wr_ok = wr_en_i && (NUM_LINES == 2 || !wr_addr_i[4]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= CHAR_BLANK;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Streams the message buffer to an LCD controller as a refresh sequence:
// [CLEAR], set line 1 address, line 1 chars, [line 2 address, line 2 chars].
// Ports: Clock, Reset (sync, active high), wr_en/wr_addr/wr_data host
// buffer write, start/busy/done control, req_valid/req_rs/req_data/req_ready
// downstream handshake. Macro LCD_SEQ_CLEAR_EN prepends the CLEAR command.
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int CHARS_PER_LINE = 16,
    parameter int NUM_LINES      = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       req_valid,
    output logic       req_rs,
    output logic [7:0] req_data,
    input  logic       req_ready
);

    localparam int IW =
        (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHARS_PER_LINE - 1);

    lcd_seq_state_e state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           valid_q, valid_d;
    logic           rs_q, rs_d;
    logic [7:0]     data_q, data_d;

    logic [4:0]     rd_addr;
    logic [7:0]     rd_data;
    logic           accept;
    logic           last_char;
    logic           finish;

    lcd_msg_buffer #(
        .NUM_LINES (NUM_LINES)
    ) u_buf (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // The next request is launched on the accepting edge, so the buffer is
    // read here at the address of the request that follows.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        rs_d      = rs_q;
        data_d    = data_q;
        rd_addr   = 5'd0;
        finish    = 1'b0;
        accept    = valid_q && req_ready;
        last_char = (idx_q == LAST_IDX);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    idx_d   = '0;
`ifdef LCD_SEQ_CLEAR_EN
                    state_d = S_CLEAR;
                    data_d  = CMD_CLEAR;
`else
                    state_d = S_ADDR_L1;
                    data_d  = CMD_SET_DDRAM;
`endif
                end
            end
`ifdef LCD_SEQ_CLEAR_EN
            S_CLEAR: begin
                if (accept) begin
                    state_d = S_ADDR_L1;
                    data_d  = CMD_SET_DDRAM;
                end
            end
`endif
            S_ADDR_L1: begin
                if (accept) begin
                    state_d = S_CHARS_L1;
                    idx_d   = '0;
                    rs_d    = 1'b1;
                    rd_addr = 5'd0;
                    data_d  = rd_data;
                end
            end
            S_CHARS_L1: begin
                if (accept) begin
                    if (!last_char) begin
                        idx_d   = idx_q + IW'(1);
                        rd_addr = 5'(idx_q) + 5'd1;
                        data_d  = rd_data;
                    end else if (NUM_LINES == 2) begin
                        state_d = S_ADDR_L2;
                        idx_d   = '0;
                        rs_d    = 1'b0;
                        data_d  = CMD_SET_DDRAM | LINE2_OFFSET;
                    end else begin
                        finish  = 1'b1;
                    end
                end
            end
            S_ADDR_L2: begin
                if (accept) begin
                    state_d = S_CHARS_L2;
                    idx_d   = '0;
                    rs_d    = 1'b1;
                    rd_addr = BUF_LINE2_BASE;
                    data_d  = rd_data;
                end
            end
            S_CHARS_L2: begin
                if (accept) begin
                    if (!last_char) begin
                        idx_d   = idx_q + IW'(1);
                        rd_addr = BUF_LINE2_BASE
                                + 5'(idx_q) + 5'd1;
                        data_d  = rd_data;
                    end else begin
                        finish  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d = S_DONE;
            idx_d   = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign req_valid = valid_q;
    assign req_rs    = rs_q;
    assign req_data  = data_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Self-checking bench for lcd_msg_sequencer: a two-line and a one-line
// instance, compared against a list-based model of the refresh sequence.
module tb_lcd_msg_sequencer;

    localparam int C = 16;
`ifdef LCD_SEQ_CLEAR_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic       Clock;
    logic       Reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       req_ready;
    bit         sel;

    logic       start0, busy0, done0, v0, rs0;
    logic [7:0] d0;
    logic       start1, busy1, done1, v1, rs1;
    logic [7:0] d1;

    logic       o_busy, o_done, o_valid, o_rs;
    logic [7:0] o_data;

    int checks;
    int errors;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];

    logic [8:0] obs_q [$];
    logic [8:0] exp_q [$];
    int gaps, changes, done_cnt, done_c, last_acc, post_err, cnt80;
    bit timeout;

    assign start0  = start & ~sel;
    assign start1  = start & sel;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_valid = sel ? v1 : v0;
    assign o_rs    = sel ? rs1 : rs0;
    assign o_data  = sel ? d1 : d0;

    lcd_msg_sequencer #(
        .CHARS_PER_LINE (16),
        .NUM_LINES      (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start0),
        .busy      (busy0),
        .done      (done0),
        .req_valid (v0),
        .req_rs    (rs0),
        .req_data  (d0),
        .req_ready (req_ready)
    );

    lcd_msg_sequencer #(
        .CHARS_PER_LINE (16),
        .NUM_LINES      (1)
    ) dut1 (
        .Clock     (Clock),
        .Reset     (Reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start1),
        .busy      (busy1),
        .done      (done1),
        .req_valid (v1),
        .req_rs    (rs1),
        .req_data  (d1),
        .req_ready (req_ready)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic int total_of(input bit s);
        return OFF + 1 + C + (s ? 0 : 1 + C);
    endfunction

    // Request p of a refresh as {rs, byte}, from the current model buffer.
    function automatic logic [8:0] exp_item(input bit s, input int p);
        int q;
        q = p - OFF;
        if (q < 0) return {1'b0, 8'h01};
        if (q == 0) return {1'b0, 8'h80};
        q = q - 1;
        if (q < C) return {1'b1, s ? mem1[q] : mem0[q]};
        q = q - C;
        if (q == 0) return {1'b0, 8'hC0};
        q = q - 1;
        return {1'b1, mem0[16 + q]};
    endfunction

    task automatic model_blank();
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'h20;
            mem1[i] = 8'h20;
        end
    endtask

    task automatic model_write(input logic [4:0] a, input logic [7:0] d);
        mem0[a] = d;
        if (!a[4]) mem1[a] = d;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        model_blank();
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge Clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_write(a, d);
        @(negedge Clock);
        wr_en = 1'b0;
    endtask

    // Runs one refresh, collecting accepted requests and the model's
    // expectation for each; optional stall, mid-run write and re-start.
    task automatic run_seq(input int stall_pos, input int stall_len,
                           input int wr_pos, input logic [4:0] wa,
                           input logic [7:0] wd, input int again_c,
                           input bit rnd);
        int pos, tot, stall_cnt;
        bit wr_pend, prev_stall, acc;
        logic [8:0] cur, prev;
        tot = total_of(sel);
        obs_q.delete();
        exp_q.delete();
        gaps = 0; changes = 0; done_cnt = 0; done_c = -1;
        last_acc = -1; post_err = 0; cnt80 = 0; timeout = 0;
        pos = 0; stall_cnt = 0; prev_stall = 0; prev = '0;
        wr_pend = (wr_pos >= 0);
        @(negedge Clock);
        exp_q.push_back(exp_item(sel, 0));
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cur = {o_rs, o_data};
            if (o_done === 1'b1) begin
                done_cnt++;
                done_c = c;
            end
            if (pos < tot && !(o_valid === 1'b1 && o_busy === 1'b1))
                gaps++;
            if (last_acc >= 0 && pos == tot && (o_valid || o_busy))
                post_err++;
            if (prev_stall && (o_valid !== 1'b1 || cur !== prev))
                changes++;
            if (o_valid === 1'b1 && cur === {1'b0, 8'h80}) cnt80++;
            req_ready = 1'b1;
            if (rnd && $urandom_range(0, 3) == 0) req_ready = 1'b0;
            if (pos == stall_pos && stall_cnt < stall_len) begin
                req_ready = 1'b0;
                stall_cnt++;
            end
            acc = (o_valid === 1'b1) && req_ready;
            wr_en = 1'b0;
            if (wr_pend && pos == wr_pos) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
                wr_pend = 0;
            end
            if (acc) begin
                obs_q.push_back(cur);
                pos++;
                last_acc = c;
                if (pos < tot) exp_q.push_back(exp_item(sel, pos));
            end
            if (wr_en) model_write(wa, wd);
            prev_stall = (o_valid === 1'b1) && !req_ready;
            prev = cur;
            start = (c == again_c);
            if (pos == tot && c >= last_acc + 3) break;
            @(negedge Clock);
            wr_en = 1'b0;
            start = 1'b0;
        end
        wr_en = 1'b0;
        start = 1'b0;
        req_ready = 1'b1;
        if (pos < tot) timeout = 1;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1; start = 1'b1; wr_en = 1'b1;
        wr_addr = 5'd9; wr_data = 8'h41; req_ready = 1'b1;
        @(negedge Clock);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got %b exp 0", o_busy);
        end
        checks++;
        if (o_done !== 1'b0) begin
            errors++; $display("FAIL rst_done got %b exp 0", o_done);
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got %b exp 0", o_valid);
        end
        checks++;
        if (o_rs !== 1'b0) begin
            errors++; $display("FAIL rst_rs got %b exp 0", o_rs);
        end
        checks++;
        if (o_data !== 8'h00) begin
            errors++; $display("FAIL rst_data got %h exp 00", o_data);
        end
        Reset = 1'b0; start = 1'b0; wr_en = 1'b0;
        model_blank();
    endtask

    task automatic test_hello();
        logic [7:0] h [5];
        h = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        sel = 0;
        for (int i = 0; i < 5; i++) host_write(5'(i), h[i]);
        run_seq(-1, 0, -1, 5'd0, 8'h00, -1, 0);
        checks++;
        if (timeout || obs_q.size() != OFF + 34) begin
            errors++;
            $display("FAIL hello_len got %0d exp %0d", obs_q.size(), OFF + 34);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hello_req%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef LCD_SEQ_CLEAR_EN
        checks++;
        if (obs_q[0] !== {1'b0, 8'h01}) begin
            errors++; $display("FAIL hello_clear got %h exp 001", obs_q[0]);
        end
`endif
        checks++;
        if (obs_q[OFF] !== {1'b0, 8'h80}) begin
            errors++; $display("FAIL hello_l1 got %h exp 080", obs_q[OFF]);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_q[OFF + 1 + i] !== {1'b1, h[i]}) begin
                errors++;
                $display("FAIL hello_ch%0d got %h exp %h", i, obs_q[OFF + 1 + i], {1'b1, h[i]});
            end
        end
        checks++;
        if (obs_q[OFF + 10] !== {1'b1, 8'h20}) begin
            errors++; $display("FAIL hello_ch9 got %h exp 120", obs_q[OFF + 10]);
        end
        checks++;
        if (obs_q[OFF + 17] !== {1'b0, 8'hC0}) begin
            errors++; $display("FAIL hello_l2 got %h exp 0C0", obs_q[OFF + 17]);
        end
        checks++;
        if (gaps != 0) begin
            errors++; $display("FAIL hello_gaps got %0d exp 0", gaps);
        end
        checks++;
        if (done_cnt != 1 || done_c != last_acc + 1) begin
            errors++;
            $display("FAIL hello_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_c, last_acc + 1);
        end
        checks++;
        if (post_err != 0) begin
            errors++; $display("FAIL hello_idle got %0d exp 0", post_err);
        end
    endtask

    task automatic test_stall();
        sel = 0;
        run_seq(OFF, 3, -1, 5'd0, 8'h00, -1, 0);
        checks++;
        if (cnt80 != 4) begin
            errors++; $display("FAIL stall_held got %0d exp 4", cnt80);
        end
        checks++;
        if (changes != 0 || gaps != 0) begin
            errors++; $display("FAIL stall_stable got %0d/%0d exp 0/0", changes, gaps);
        end
        checks++;
        if (timeout || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_len got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_req%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_c != last_acc + 1) begin
            errors++; $display("FAIL stall_done got %0d at %0d", done_cnt, done_c);
        end
    endtask

    task automatic test_restart();
        int extra;
        sel = 0;
        run_seq(-1, 0, -1, 5'd0, 8'h00, 5, 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
                extra++;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL restart_done got %0d exp 1", done_cnt);
        end
        checks++;
        if (timeout || obs_q.size() != total_of(0) || extra != 0) begin
            errors++;
            $display("FAIL restart_seq got %0d extra %0d exp %0d extra 0", obs_q.size(), extra, total_of(0));
        end
    endtask

    task automatic test_reset_mid();
        int pos, target;
        sel = 0;
        for (int i = 0; i < 32; i++)
            host_write(5'(i), 8'($urandom_range(33, 126)));
        target = OFF + 1 + 5;
        pos = 0;
        req_ready = 1'b1;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (pos == target) break;
            if (o_valid === 1'b1) pos++;
            @(negedge Clock);
        end
        checks++;
        if (pos != target || o_valid !== 1'b1 || o_data !== mem0[5]) begin
            errors++;
            $display("FAIL midrst_pending got %0d %b %h exp %0d 1 %h", pos, o_valid, o_data, target, mem0[5]);
        end
        Reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5;
        wr_data = 8'h55; start = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; wr_en = 1'b0; start = 1'b0;
        model_blank();
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort got %b%b exp 00", o_valid, o_busy);
        end
        run_seq(-1, 0, -1, 5'd0, 8'h00, -1, 0);
        checks++;
        if (obs_q[OFF + 6] !== {1'b1, 8'h20}) begin
            errors++; $display("FAIL midrst_blank got %h exp 120", obs_q[OFF + 6]);
        end
        checks++;
        if (timeout || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_len got %0d", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_req%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_midwrite();
        sel = 0;
        do_reset();
        run_seq(-1, 0, OFF + 3, 5'd20, 8'h5A, -1, 0);
        checks++;
        if (obs_q[OFF + C + 6] !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL midwr_z got %h exp 15A", obs_q[OFF + C + 6]);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midwr_req%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        do_reset();
        run_seq(-1, 0, OFF + 3, 5'd3, 8'h57, -1, 0);
        checks++;
        if (obs_q[OFF + 4] !== {1'b1, 8'h20}) begin
            errors++; $display("FAIL samecyc_old got %h exp 120", obs_q[OFF + 4]);
        end
    endtask

    task automatic test_one_line();
        int c0;
        sel = 1;
        do_reset();
        host_write(5'd4, 8'h52);
        host_write(5'd20, 8'h51);
        run_seq(-1, 0, -1, 5'd0, 8'h00, -1, 0);
        checks++;
        if (timeout || obs_q.size() != OFF + 17) begin
            errors++;
            $display("FAIL one_len got %0d exp %0d", obs_q.size(), OFF + 17);
        end
        checks++;
        if (obs_q[OFF] !== {1'b0, 8'h80}) begin
            errors++; $display("FAIL one_first got %h exp 080", obs_q[OFF]);
        end
        checks++;
        if (obs_q[OFF + 5] !== {1'b1, 8'h52}) begin
            errors++; $display("FAIL one_alias got %h exp 152", obs_q[OFF + 5]);
        end
        c0 = 0;
        foreach (obs_q[i]) if (obs_q[i] === {1'b0, 8'hC0}) c0++;
        checks++;
        if (c0 != 0) begin
            errors++; $display("FAIL one_noc0 got %0d exp 0", c0);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL one_req%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_c != last_acc + 1) begin
            errors++; $display("FAIL one_done got %0d at %0d", done_cnt, done_c);
        end
        sel = 0;
    endtask

    task automatic test_random();
        int tot;
        for (int it = 0; it < 6; it++) begin
            sel = it[0];
            tot = total_of(sel);
            for (int k = 0; k < 4; k++)
                host_write(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
            run_seq($urandom_range(0, tot - 1), $urandom_range(0, 4),
                    $urandom_range(0, tot - 1), 5'($urandom_range(0, 31)),
                    8'($urandom_range(33, 126)), -1, 1);
            checks++;
            if (timeout || obs_q.size() != tot || gaps != 0 || changes != 0) begin
                errors++;
                $display("FAIL rnd%0d_flow got %0d g%0d c%0d exp %0d", it, obs_q.size(), gaps, changes, tot);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_req%0d got %h exp %h", it, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (done_cnt != 1 || done_c != last_acc + 1) begin
                errors++; $display("FAIL rnd%0d_done got %0d at %0d", it, done_cnt, done_c);
            end
        end
        sel = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel = 0;
        Reset = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        req_ready = 1'b1;
        model_blank();
        test_reset();
        test_hello();
        test_stall();
        test_restart();
        test_reset_mid();
        test_midwrite();
        test_one_line();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
